sir_reg_bank: RTL and testbench
===============================

// Module: sir_reg_bank
// PURPOSE
//  Register-bank slave on the SIR strobe bus driven by the AXI-lite -> SIR bridge (csr_pro).
//  Decodes one 256-byte page and provides:
//   - version, scratch, self-clearing pulse, IRQ and 8 control/8 status registers.
//  Sole owner of sir_dack/sir_rdat within its page; outputs are 0 when idle, so several banks OR onto the bus.
// PARAMETERS
//  BASE_PAGE  8'h00         sir_addr[15:8] value this bank answers
//  VERSION    32'h0001_0000 value returned at offset 0x00
//  IRQ_W      16            number of interrupt sources (1..32)
// PORTS
//  clk        in   1      bus/system clock
//  rst        in   1      asynchronous reset, active-high
//  sir_sel    in   1      request; addr/read/wdat stable while high; held until dack
//  sir_addr   in   16     byte address; [1:0] ignored
//  sir_read   in   1      1=read, 0=write
//  sir_wdat   in   32     write data
//  sir_rdat   out  32     read data; valid only with sir_dack, else 0
//  sir_dack   out  1      one-cycle acknowledge
//  ctrl_reg   out  256    CTRL[0..7], CTRL[i] = ctrl_reg[32*i+:32]
//  stat_in    in   256    STAT[0..7], sampled at read decode
//  ctrl_pulse out  32     one-cycle pulses from PULSE write
//  irq_src    in   IRQ_W  level sources, rising edge latches status
//  irq        out  1      registered OR of (IRQ_STATUS & IRQ_EN)
// BEHAVIOUR
//  Reset: all outputs 0; SCRATCH/CTRL/IRQ_EN/IRQ_STATUS = 0; edge-detect history = 0; FSM = IDLE.
//  FSM: IDLE -> (sel & page hit) DECODE -> ACK -> HOLD -> (sel==0) IDLE.
//       IDLE -> (sel & page miss) HOLD; no dack, no side effects.
//  Timing: sel first high in cycle 0; DECODE in cycle 1, where the write commits and the read mux is registered.
//    sir_dack=1 and rdat valid in cycle 2 only.
//    Write effects (ctrl_reg, ctrl_pulse) are visible from cycle 2.
//  HOLD blocks re-acceptance until sel drops: exactly one access per sel assertion.
//  Map (offset = addr[7:0]):
//   0x00 VERSION RO
//   0x04 SCRATCH RW
//   0x08 PULSE WO: written 1-bits pulse ctrl_pulse for one cycle; reads 0
//   0x0C IRQ_STATUS W1C
//   0x10 IRQ_EN RW
//   0x14 IRQ_RAW RO: current irq_src levels
//   0x20+4i CTRL[i] RW
//   0x40+4i STAT[i] RO
//  Unmapped in-page offsets: read 32'hDEAD_BEEF; writes ignored; dack still given.
//  Writes to RO offsets are ignored and acked.
//  Bits above IRQ_W in IRQ registers read 0 and ignore writes.
//  IRQ: irq_src registered once; rising edge (src & ~prev) sets the STATUS bit.
//    A set on the same cycle as a W1C clear of that bit: set wins.
//    irq updates one cycle after STATUS/EN change.
//  Reset mid-transaction: dack/rdat forced 0, no partial write; a sel held across reset is serviced once afterwards.
//  Widths: no arithmetic; all registers exactly 32 bit.
// STRUCTURE
//  Package sir_reg_pkg:
//   - offset localparams (OFS_VERSION..OFS_STAT0)
//   - RD_UNMAPPED = 32'hDEAD_BEEF
//   - FSM state encoding {IDLE, DECODE, ACK, HOLD}
//  Sub-module sir_irq_ctrl (IRQ_W): edge detect, STATUS W1C, EN, irq output; bank drives its write strobes.
//  Top holds FSM, address latch, write decode and registered read mux.
// TESTING
//  Write 0x04 = 0xA5A5_1234, then read 0x04 -> dack exactly 2 cycles after sel; rdat = 0xA5A5_1234; one dack per sel.
//  Write 0x08 = 0x0000_0011 -> ctrl_pulse = 0x11 for exactly one cycle (cycle 2); read 0x08 = 0.
//  irq_src[3] rises, EN = 0x8 -> STATUS = 0x8, irq=1; write 0x0C = 0x8 -> STATUS = 0, irq=0 next cycle.
//   Repeat with a new edge coinciding with the clear: STATUS stays 0x8.
//  Read 0x7C -> 0xDEAD_BEEF with dack.
//   sir_addr = {BASE_PAGE+1, 8'h04} -> no dack, sir_rdat = 0 for 10 cycles, no register change.
//  Write CTRL[5] (0x34) = 0xFFFF_0000 -> ctrl_reg[191:160] updates in cycle 2.
//   stat_in[63:32] = 0x1357 -> read 0x44 = 0x1357.
//  Assert rst in cycle 1 of a write to 0x04 -> SCRATCH stays 0, no dack.
//   Keep sel high after reset -> single serviced access with dack.

Source files
------------

// File: rtl/sir_reg_pkg.sv
// sir_reg_pkg: register offsets, unmapped read value and FSM encoding for sir_reg_bank
package sir_reg_pkg;
  localparam logic [7:0] OFS_VERSION    = 8'h00;
  localparam logic [7:0] OFS_SCRATCH    = 8'h04;
  localparam logic [7:0] OFS_PULSE      = 8'h08;
  localparam logic [7:0] OFS_IRQ_STATUS = 8'h0C;
  localparam logic [7:0] OFS_IRQ_EN     = 8'h10;
  localparam logic [7:0] OFS_IRQ_RAW    = 8'h14;
  localparam logic [7:0] OFS_CTRL0      = 8'h20;
  localparam logic [7:0] OFS_STAT0      = 8'h40;
  localparam logic [31:0] RD_UNMAPPED   = 32'hDEAD_BEEF;
  typedef enum logic [1:0] {IDLE, DECODE, ACK, HOLD} state_t;
endpackage

// File: rtl/sir_irq_ctrl.sv
// sir_irq_ctrl: rising-edge interrupt latch with W1C status, enable mask and registered irq
module sir_irq_ctrl #(
  parameter int IRQ_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IRQ_W-1:0] irq_src,
  input  logic             clr_we,
  input  logic             en_we,
  input  logic [IRQ_W-1:0] wdat,
  output logic [31:0]      status,
  output logic [31:0]      en,
  output logic [31:0]      raw,
  output logic             irq
);
  logic [IRQ_W-1:0] src_q, prev_q, sts, en_r, rise;
  assign rise   = src_q & ~prev_q;
  assign status = 32'(sts);
  assign en     = 32'(en_r);
  assign raw    = 32'(irq_src);
  // a new edge in the same cycle as a W1C clear keeps the bit set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q  <= '0;
      prev_q <= '0;
      sts    <= '0;
      en_r   <= '0;
      irq    <= 1'b0;
    end else begin
      src_q  <= irq_src;
      prev_q <= src_q;
      sts    <= (clr_we ? sts & ~wdat : sts) | rise;
      en_r   <= en_we ? wdat : en_r;
      irq    <= |(sts & en_r);
    end
  end
endmodule

// File: rtl/sir_reg_bank.sv
// sir_reg_bank: one-page SIR register bank with version, scratch, pulse, IRQ, CTRL and STAT registers
module sir_reg_bank
  import sir_reg_pkg::*;
#(
  parameter logic [7:0]  BASE_PAGE = 8'h00,
  parameter logic [31:0] VERSION   = 32'h0001_0000,
  parameter int          IRQ_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sir_sel,
  input  logic [15:0]      sir_addr,
  input  logic             sir_read,
  input  logic [31:0]      sir_wdat,
  output logic [31:0]      sir_rdat,
  output logic             sir_dack,
  output logic [255:0]     ctrl_reg,
  input  logic [255:0]     stat_in,
  output logic [31:0]      ctrl_pulse,
  input  logic [IRQ_W-1:0] irq_src,
  output logic             irq
);
  state_t      state;
  logic [5:0]  w;
  logic        rd_q, wen, is_ctrl, is_stat, unused;
  logic [31:0] scratch, rd_val, irq_status, irq_en, irq_raw;
  assign unused  = ^sir_addr[1:0];
  assign wen     = state == DECODE && !rd_q;
  assign is_ctrl = w[5:3] == OFS_CTRL0[7:5];
  assign is_stat = w[5:3] == OFS_STAT0[7:5];
  sir_irq_ctrl #(.IRQ_W(IRQ_W)) u_irq (
    .clk    (clk),
    .rst    (rst),
    .irq_src(irq_src),
    .clr_we (wen && w == OFS_IRQ_STATUS[7:2]),
    .en_we  (wen && w == OFS_IRQ_EN[7:2]),
    .wdat   (sir_wdat[IRQ_W-1:0]),
    .status (irq_status),
    .en     (irq_en),
    .raw    (irq_raw),
    .irq    (irq)
  );
  always_comb begin
    rd_val = w == OFS_VERSION[7:2]    ? VERSION :
             w == OFS_SCRATCH[7:2]    ? scratch :
             w == OFS_PULSE[7:2]      ? 32'h0 :
             w == OFS_IRQ_STATUS[7:2] ? irq_status :
             w == OFS_IRQ_EN[7:2]     ? irq_en :
             w == OFS_IRQ_RAW[7:2]    ? irq_raw :
             is_ctrl                  ? ctrl_reg[{w[2:0], 5'b0} +: 32] :
             is_stat                  ? stat_in[{w[2:0], 5'b0} +: 32] :
                                        RD_UNMAPPED;
  end
  // page misses go straight to HOLD so the access is swallowed until sel drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      w          <= '0;
      rd_q       <= 1'b0;
      sir_dack   <= 1'b0;
      sir_rdat   <= '0;
      scratch    <= '0;
      ctrl_reg   <= '0;
      ctrl_pulse <= '0;
    end else begin
      sir_dack   <= 1'b0;
      sir_rdat   <= '0;
      ctrl_pulse <= '0;
      case (state)
        IDLE: if (sir_sel) begin
          w     <= sir_addr[7:2];
          rd_q  <= sir_read;
          state <= sir_addr[15:8] == BASE_PAGE ? DECODE : HOLD;
        end
        DECODE: begin
          state    <= ACK;
          sir_dack <= 1'b1;
          if (rd_q) sir_rdat <= rd_val;
          else begin
            if (w == OFS_SCRATCH[7:2]) scratch <= sir_wdat;
            if (w == OFS_PULSE[7:2]) ctrl_pulse <= sir_wdat;
            if (is_ctrl) ctrl_reg[{w[2:0], 5'b0} +: 32] <= sir_wdat;
          end
        end
        ACK:  state <= HOLD;
        HOLD: if (!sir_sel) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sir_reg_bank.sv
// tb_sir_reg_bank: directed self-checking bench for sir_reg_bank
module tb_sir_reg_bank;
  logic         clk = 1'b0, rst = 1'b1, sir_sel = 1'b0, sir_read = 1'b0, sir_dack, irq;
  logic [15:0]  sir_addr = '0, irq_src = '0;
  logic [31:0]  sir_wdat = '0, sir_rdat, ctrl_pulse;
  logic [255:0] ctrl_reg, stat_in = '0;
  int           errors = 0, checks = 0, ack_cnt, ack_cyc, bad_idle;
  logic [31:0]  rdat_q, pulse_log, pulse_c2;
  logic [255:0] ctrl_c1, ctrl_c2;
  logic         irq_c2, irq_c3;

  sir_reg_bank dut (
    .clk(clk), .rst(rst), .sir_sel(sir_sel), .sir_addr(sir_addr), .sir_read(sir_read),
    .sir_wdat(sir_wdat), .sir_rdat(sir_rdat), .sir_dack(sir_dack), .ctrl_reg(ctrl_reg),
    .stat_in(stat_in), .ctrl_pulse(ctrl_pulse), .irq_src(irq_src), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic watch(input int n);
    ack_cnt = 0; ack_cyc = -1; bad_idle = 0; pulse_log = '0; rdat_q = '0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      #1;
      if (sir_dack) begin
        ack_cnt++;
        if (ack_cyc < 0) ack_cyc = c;
        rdat_q = sir_rdat;
        sir_sel = 1'b0;
      end else if (sir_rdat !== 32'h0) bad_idle++;
      pulse_log[c] = |ctrl_pulse;
      if (c == 1) ctrl_c1 = ctrl_reg;
      if (c == 2) begin ctrl_c2 = ctrl_reg; pulse_c2 = ctrl_pulse; irq_c2 = irq; end
      if (c == 3) irq_c3 = irq;
    end
    sir_sel = 1'b0;
  endtask

  task automatic access(input logic rd, input logic [15:0] a, input logic [31:0] d, input int n);
    sir_sel = 1'b1; sir_read = rd; sir_addr = a; sir_wdat = d;
    watch(n);
  endtask

  task automatic test_reset;
    checks++; if (sir_dack !== 1'b0 || sir_rdat !== 32'h0) begin errors++; $display("FAIL reset_bus dack=%b rdat=%h want 0/0", sir_dack, sir_rdat); end
    checks++; if (ctrl_reg !== '0 || ctrl_pulse !== 32'h0 || irq !== 1'b0) begin errors++; $display("FAIL reset_out ctrl=%h pulse=%h irq=%b want 0", ctrl_reg, ctrl_pulse, irq); end
    rst = 1'b0;
    tick(1);
    access(1'b1, 16'h0000, 32'h0, 8);
    checks++; if (rdat_q !== 32'h0001_0000 || ack_cnt != 1) begin errors++; $display("FAIL reset_version rdat=%h acks=%0d want 00010000/1", rdat_q, ack_cnt); end
    access(1'b1, 16'h0004, 32'h0, 8);
    checks++; if (rdat_q !== 32'h0) begin errors++; $display("FAIL reset_scratch rdat=%h want 0", rdat_q); end
  endtask

  task automatic test_scratch;
    access(1'b0, 16'h0004, 32'hA5A5_1234, 8);
    checks++; if (ack_cyc != 2 || ack_cnt != 1) begin errors++; $display("FAIL scratch_wr_ack cyc=%0d cnt=%0d want 2/1", ack_cyc, ack_cnt); end
    access(1'b1, 16'h0004, 32'h0, 8);
    checks++; if (ack_cyc != 2 || ack_cnt != 1) begin errors++; $display("FAIL scratch_rd_ack cyc=%0d cnt=%0d want 2/1", ack_cyc, ack_cnt); end
    checks++; if (rdat_q !== 32'hA5A5_1234) begin errors++; $display("FAIL scratch_rd rdat=%h want a5a51234", rdat_q); end
    access(1'b0, 16'h0000, 32'h1111_2222, 8);
    access(1'b1, 16'h0000, 32'h0, 8);
    checks++; if (rdat_q !== 32'h0001_0000) begin errors++; $display("FAIL version_ro rdat=%h want 00010000", rdat_q); end
  endtask

  task automatic test_pulse;
    access(1'b0, 16'h0008, 32'h0000_0011, 8);
    checks++; if (pulse_c2 !== 32'h11) begin errors++; $display("FAIL pulse_val got=%h want 11", pulse_c2); end
    checks++; if (pulse_log !== 32'h4) begin errors++; $display("FAIL pulse_cycles log=%h want 4", pulse_log); end
    access(1'b1, 16'h0008, 32'h0, 8);
    checks++; if (rdat_q !== 32'h0 || ack_cnt != 1) begin errors++; $display("FAIL pulse_rd rdat=%h acks=%0d want 0/1", rdat_q, ack_cnt); end
  endtask

  task automatic test_irq;
    access(1'b0, 16'h0010, 32'h0000_0008, 8);
    irq_src = 16'h0008;
    tick(4);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set irq=%b want 1", irq); end
    access(1'b1, 16'h000C, 32'h0, 8);
    checks++; if (rdat_q !== 32'h8) begin errors++; $display("FAIL irq_status rdat=%h want 8", rdat_q); end
    access(1'b1, 16'h0014, 32'h0, 8);
    checks++; if (rdat_q !== 32'h8) begin errors++; $display("FAIL irq_raw rdat=%h want 8", rdat_q); end
    access(1'b0, 16'h000C, 32'h0000_0008, 8);
    checks++; if (irq_c2 !== 1'b1 || irq_c3 !== 1'b0) begin errors++; $display("FAIL irq_clear_timing c2=%b c3=%b want 1/0", irq_c2, irq_c3); end
    access(1'b1, 16'h000C, 32'h0, 8);
    checks++; if (rdat_q !== 32'h0) begin errors++; $display("FAIL irq_cleared rdat=%h want 0", rdat_q); end
    irq_src = 16'h0;
    tick(3);
    irq_src = 16'h0008;
    tick(4);
    irq_src = 16'h0;
    tick(3);
    irq_src = 16'h0008;
    access(1'b0, 16'h000C, 32'h0000_0008, 8);
    checks++; if (irq_c3 !== 1'b1 || irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins c3=%b irq=%b want 1/1", irq_c3, irq); end
    access(1'b1, 16'h000C, 32'h0, 8);
    checks++; if (rdat_q !== 32'h8) begin errors++; $display("FAIL irq_set_wins_status rdat=%h want 8", rdat_q); end
    access(1'b0, 16'h0010, 32'hFFFF_FFFF, 8);
    access(1'b1, 16'h0010, 32'h0, 8);
    checks++; if (rdat_q !== 32'h0000_FFFF) begin errors++; $display("FAIL irq_en_width rdat=%h want 0000ffff", rdat_q); end
  endtask

  task automatic test_decode;
    access(1'b1, 16'h007C, 32'h0, 8);
    checks++; if (rdat_q !== 32'hDEAD_BEEF || ack_cnt != 1) begin errors++; $display("FAIL unmapped rdat=%h acks=%0d want deadbeef/1", rdat_q, ack_cnt); end
    access(1'b0, 16'h0104, 32'h5555_AAAA, 10);
    checks++; if (ack_cnt != 0 || bad_idle != 0) begin errors++; $display("FAIL page_miss acks=%0d busy_rdat=%0d want 0/0", ack_cnt, bad_idle); end
    tick(2);
    access(1'b1, 16'h0004, 32'h0, 8);
    checks++; if (rdat_q !== 32'hA5A5_1234) begin errors++; $display("FAIL page_miss_nochg rdat=%h want a5a51234", rdat_q); end
  endtask

  task automatic test_ctrl_stat;
    access(1'b0, 16'h0034, 32'hFFFF_0000, 8);
    checks++; if (ctrl_c1[191:160] !== 32'h0 || ctrl_c2[191:160] !== 32'hFFFF_0000) begin errors++; $display("FAIL ctrl5_timing c1=%h c2=%h want 0/ffff0000", ctrl_c1[191:160], ctrl_c2[191:160]); end
    checks++; if (ctrl_reg[159:0] !== '0 || ctrl_reg[255:192] !== '0) begin errors++; $display("FAIL ctrl_others nonzero outside ctrl5"); end
    access(1'b1, 16'h0034, 32'h0, 8);
    checks++; if (rdat_q !== 32'hFFFF_0000) begin errors++; $display("FAIL ctrl5_rd rdat=%h want ffff0000", rdat_q); end
    stat_in[63:32] = 32'h0000_1357;
    access(1'b1, 16'h0044, 32'h0, 8);
    checks++; if (rdat_q !== 32'h0000_1357) begin errors++; $display("FAIL stat1_rd rdat=%h want 00001357", rdat_q); end
  endtask

  task automatic test_reset_mid;
    sir_sel = 1'b1; sir_read = 1'b0; sir_addr = 16'h0004; sir_wdat = 32'h0BAD_F00D;
    tick(1);
    rst = 1'b1;
    #1;
    checks++; if (sir_dack !== 1'b0 || sir_rdat !== 32'h0) begin errors++; $display("FAIL rst_mid_bus dack=%b rdat=%h want 0/0", sir_dack, sir_rdat); end
    @(posedge clk);
    #1;
    checks++; if (dut.scratch !== 32'h0 || sir_dack !== 1'b0) begin errors++; $display("FAIL rst_mid_nowrite scratch=%h dack=%b want 0/0", dut.scratch, sir_dack); end
    rst = 1'b0;
    watch(8);
    checks++; if (ack_cnt != 1 || ack_cyc != 2) begin errors++; $display("FAIL rst_resume acks=%0d cyc=%0d want 1/2", ack_cnt, ack_cyc); end
    access(1'b1, 16'h0004, 32'h0, 8);
    checks++; if (rdat_q !== 32'h0BAD_F00D) begin errors++; $display("FAIL rst_resume_data rdat=%h want 0badf00d", rdat_q); end
  endtask

  initial begin
    tick(2);
    test_reset;
    test_scratch;
    test_pulse;
    test_irq;
    test_decode;
    test_ctrl_stat;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
